tx_rs_frame_seq: RTL and testbench

Codeword sequencer between the TX byte interface and the lane-0 RS encoder. It cuts the outgoing byte stream into RS codewords of RS_K data symbols, each marked with sop and eop. After every codeword it holds off upstream for the RS_N-RS_K parity slots the encoder needs. It also handles frame ends that fall mid-codeword and counts transmitted codewords.

---
 rtl/tx_rs_frame_seq_pkg.sv | 22 ++
 rtl/tx_rs_frame_seq_if.sv | 32 +++
 rtl/tx_rs_frame_seq_oreg.sv | 63 ++++++
 rtl/tx_rs_frame_seq.sv | 155 +++++++++++++++
 tb/tb_tx_rs_frame_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_rs_frame_seq_pkg.sv
// Shared types and constants for the TX RS codeword sequencer.
// Holds the FSM state type, default code sizes, pad byte and counter width helper.
package tx_rs_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    PAD   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam int RS_N_DFLT = 255;
  localparam int RS_K_DFLT = 239;
  localparam int RS_NPAR   = RS_N_DFLT - RS_K_DFLT;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_rs_frame_seq_if.sv
// Byte-stream bundle: upstream byte port and encoder symbol port.
// master = sequencer side, slave = the surrounding logic / bench.
interface tx_rs_frame_seq_if;
  import tx_rs_seq_pkg::*;

  logic       i_in_val;
  logic       i_in_sof;
  logic       i_in_eof;
  logic [7:0] i_in_data;
  logic       o_in_rdy;

  logic       o_enc_val;
  logic       o_enc_sop;
  logic       o_enc_eop;
  logic [7:0] o_enc_data;
  logic       i_enc_rdy;

  modport master (
    input  i_in_val, i_in_sof, i_in_eof,
    input  i_in_data, i_enc_rdy,
    output o_in_rdy, o_enc_val, o_enc_sop,
    output o_enc_eop, o_enc_data
  );

  modport slave (
    output i_in_val, i_in_sof, i_in_eof,
    output i_in_data, i_enc_rdy,
    input  o_in_rdy, o_enc_val, o_enc_sop,
    input  o_enc_eop, o_enc_data
  );

endinterface

// File: rtl/tx_rs_frame_seq_oreg.sv
// Single-entry valid/ready output register for data/sop/eop.
// Ports: i_push loads a symbol (only when o_free), i_rdy drains it.
module tx_rs_seq_oreg
  import tx_rs_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_sop,
  input  logic       i_eop,
  input  logic       i_rdy,
  output logic       o_val,
  output logic       o_sop,
  output logic       o_eop,
  output logic [7:0] o_data,
  output logic       o_free
);

  logic       val_q, val_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic [7:0] data_q, data_d;

  assign o_free = ~val_q | i_rdy;

  always_comb begin
    val_d  = val_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    data_d = data_q;
    if (i_push) begin
      val_d  = 1'b1;
      sop_d  = i_sop;
      eop_d  = i_eop;
      data_d = i_data;
    end else if (i_rdy) begin
      val_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      data_q <= PAD_BYTE;
    end else begin
      val_q  <= val_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      data_q <= data_d;
    end
  end

  assign o_val  = val_q;
  assign o_sop  = sop_q;
  assign o_eop  = eop_q;
  assign o_data = data_q;

endmodule

// File: rtl/tx_rs_frame_seq.sv
// Cuts the TX byte stream into RS_K-symbol codewords (sop/eop) with an
// RS_N-RS_K cycle parity gap after each; counts codewords, flags stray sof.
// Ports: clk/rst, i_en, bus (byte + encoder ports), o_busy, o_cw_cnt,
// o_err_sof. Macro TX_RS_PAD_EN: pad short final codewords with zeros.
module tx_rs_frame_seq
  import tx_rs_seq_pkg::*;
#(
  parameter int RS_N = RS_N_DFLT,
  parameter int RS_K = RS_N_DFLT - RS_NPAR
) (
  input  logic        i_vl_tx_clk,
  input  logic        i_vl_tx_rst_n,
  input  logic        i_en,
  tx_rs_frame_seq_if.master bus,
  output logic        o_busy,
  output logic [15:0] o_cw_cnt,
  output logic        o_err_sof
);

  localparam int CW = cnt_w(RS_N);
  localparam logic [CW-1:0] LAST = CW'(RS_K - 1);
  localparam logic [CW-1:0] PEND = CW'(RS_N - RS_K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] sym_q, sym_d;
  logic [CW-1:0] par_q, par_d;
  logic          open_q, open_d;
  logic          err_q, err_d;
  logic [15:0]   cw_q, cw_d;
  logic          run_q;

  logic       in_rdy, byte_in, push;
  logic [7:0] p_data;
  logic       p_sop, p_eop;
  logic       enc_val, enc_sop, enc_eop, enc_free;
  logic [7:0] enc_data;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    par_d   = par_q;
    open_d  = open_q;
    err_d   = 1'b0;
    cw_d    = cw_q;
    in_rdy  = 1'b0;
    byte_in = 1'b0;
    push    = 1'b0;
    p_data  = bus.i_in_data;
    p_sop   = (sym_q == '0);
    p_eop   = 1'b0;
    if (enc_val && bus.i_enc_rdy && enc_eop)
      cw_d = cw_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        // run_q keeps o_in_rdy low while reset is asserted
        in_rdy  = run_q & i_en & enc_free;
        byte_in = in_rdy & bus.i_in_val & bus.i_in_sof;
      end
      DATA: begin
        in_rdy  = enc_free;
        byte_in = in_rdy & bus.i_in_val;
        err_d   = byte_in & bus.i_in_sof;
      end
`ifdef TX_RS_PAD_EN
      PAD: begin
        push   = enc_free;
        p_data = PAD_BYTE;
        p_eop  = (sym_q == LAST);
        if (push) begin
          sym_d = p_eop ? '0 : sym_q + 1'b1;
          if (p_eop)
            state_d = CHECK;
        end
      end
`endif
      CHECK: begin
        // gap is counted only once the eop symbol has left
        if (!enc_val) begin
          par_d = par_q + 1'b1;
          if (par_q == PEND) begin
            par_d   = '0;
            state_d = (open_q & i_en) ? DATA : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (byte_in) begin
      push    = 1'b1;
      open_d  = ~bus.i_in_eof;
      p_eop   = (sym_q == LAST);
      sym_d   = sym_q + 1'b1;
      state_d = DATA;
      if (p_eop) begin
        sym_d   = '0;
        state_d = CHECK;
      end else if (bus.i_in_eof) begin
`ifdef TX_RS_PAD_EN
        state_d = PAD;
`else
        p_eop   = 1'b1;
        sym_d   = '0;
        state_d = CHECK;
`endif
      end
    end
    if (state_d == IDLE)
      open_d = 1'b0;
  end

  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
      par_q   <= '0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      cw_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      par_q   <= par_d;
      open_q  <= open_d;
      err_q   <= err_d;
      cw_q    <= cw_d;
      run_q   <= 1'b1;
    end
  end

  tx_rs_seq_oreg u_oreg (
    .clk    (i_vl_tx_clk),
    .rst_n  (i_vl_tx_rst_n),
    .i_push (push),
    .i_data (p_data),
    .i_sop  (p_sop),
    .i_eop  (p_eop),
    .i_rdy  (bus.i_enc_rdy),
    .o_val  (enc_val),
    .o_sop  (enc_sop),
    .o_eop  (enc_eop),
    .o_data (enc_data),
    .o_free (enc_free)
  );

  assign bus.o_in_rdy   = in_rdy;
  assign bus.o_enc_val  = enc_val;
  assign bus.o_enc_sop  = enc_sop;
  assign bus.o_enc_eop  = enc_eop;
  assign bus.o_enc_data = enc_data;
  assign o_busy         = (state_q != IDLE);
  assign o_cw_cnt       = cw_q;
  assign o_err_sof      = err_q;

endmodule

// File: tb/tb_tx_rs_frame_seq.sv
// Self-checking bench for tx_rs_frame_seq with RS_N=20, RS_K=16.
// Random payloads are checked against a codeword-chunking reference model.
module tb_tx_rs_frame_seq;

  localparam int N    = 20;
  localparam int K    = 16;
  localparam int NPAR = N - K;
`ifdef TX_RS_PAD_EN
  localparam bit PADM = 1'b1;
`else
  localparam bit PADM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        busy;
  logic        err;
  logic [15:0] cw;

  tx_rs_frame_seq_if bus();

  tx_rs_frame_seq #(.RS_N(N), .RS_K(K)) dut (
    .i_vl_tx_clk   (clk),
    .i_vl_tx_rst_n (rst_n),
    .i_en          (en),
    .bus           (bus),
    .o_busy        (busy),
    .o_cw_cnt      (cw),
    .o_err_sof     (err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int rdy_mode = 0;
  int exp_cw = 0;
  int tight = 0;
  int tight_from = 0;
  int cyc = 0;
  int last_eop = 0;
  int gap_left = 0;
  int err_cnt = 0;
  bit stall = 1'b0;
  logic [9:0] prev = '0;
  logic [9:0] got[$];
  logic [9:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1)
      bus.i_enc_rdy = ~bus.i_enc_rdy;
    else if (rdy_mode == 2)
      bus.i_enc_rdy = 1'($urandom_range(0, 1));
    else
      bus.i_enc_rdy = 1'b1;
  end

  // output monitor: collects transferred symbols, checks hold and gap
  always @(negedge clk) begin
    logic [9:0] sym;
    cyc++;
    sym = {bus.o_enc_data, bus.o_enc_sop, bus.o_enc_eop};
    if (!rst_n) begin
      stall    = 1'b0;
      gap_left = 0;
    end else begin
      if (stall) begin
        chk("hold_val", 32'(bus.o_enc_val), 1);
        chk("hold_sym", 32'(sym), 32'(prev));
      end
      if (gap_left > 0) begin
        chk("gap_in_rdy", 32'(bus.o_in_rdy), 0);
        chk("gap_enc_val", 32'(bus.o_enc_val), 0);
        gap_left--;
      end
      if (err)
        err_cnt++;
      if (bus.o_enc_val && bus.i_enc_rdy) begin
        got.push_back(sym);
        if (bus.o_enc_sop && tight != 0 && last_eop > tight_from)
          chk("cw_gap_len", 32'(cyc - last_eop), NPAR + 2);
        if (bus.o_enc_eop) begin
          gap_left = NPAR;
          last_eop = cyc;
        end
      end
      stall = bus.o_enc_val && !bus.i_enc_rdy;
      prev  = sym;
    end
  end

  task automatic put(input logic [7:0] d, input bit s, input bit e);
    int t = 0;
    bus.i_in_val  = 1'b1;
    bus.i_in_sof  = s;
    bus.i_in_eof  = e;
    bus.i_in_data = d;
    @(negedge clk);
    while (!bus.o_in_rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000)
      chk("in_rdy_timeout", 32'(t), 0);
    @(posedge clk);
    #1;
    bus.i_in_val = 1'b0;
    bus.i_in_sof = 1'b0;
    bus.i_in_eof = 1'b0;
  endtask

  // reference: K-symbol chunks, sop on each chunk start, closing rule
  task automatic model(input logic [7:0] d[$], input bit close);
    int len = d.size();
    int r = len % K;
    for (int i = 0; i < len; i++) begin
      bit s = (i % K) == 0;
      bit e = ((i % K) == K - 1) ||
              (close && !PADM && i == len - 1);
      expq.push_back({d[i], s, e});
    end
    if (close && PADM && r != 0)
      for (int j = r; j < K; j++)
        expq.push_back({8'h00, 1'b0, j == K - 1});
    exp_cw += (len + K - 1) / K;
  endtask

  task automatic send_frame(input int len, input int inj,
                            input bit close, input int en_off);
    logic [7:0] d[$];
    for (int i = 0; i < len; i++)
      d.push_back(8'($urandom));
    for (int i = 0; i < len; i++) begin
      if (i == en_off)
        en = 1'b0;
      put(d[i], i == 0 || i == inj, close && i == len - 1);
    end
    model(d, close);
  endtask

  task automatic finish_test(input string tag);
    int t = 0;
    int n;
    while ((busy || bus.o_enc_val || got.size() < expq.size())
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (NPAR + 2) @(negedge clk);
    chk({tag, "_drain"}, 32'(t < 3000), 1);
    chk({tag, "_len"}, 32'(got.size()), 32'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_sym"}, 32'(got[i]), 32'(expq[i]));
    chk({tag, "_cw_cnt"}, 32'(cw), 32'(exp_cw));
    got.delete();
    expq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    bus.i_in_val  = 1'b0;
    bus.i_in_sof  = 1'b0;
    bus.i_in_eof  = 1'b0;
    bus.i_in_data = 8'h00;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(bus.o_in_rdy), 0);
    chk("rst_enc_val", 32'(bus.o_enc_val), 0);
    chk("rst_enc_sop", 32'(bus.o_enc_sop), 0);
    chk("rst_enc_eop", 32'(bus.o_enc_eop), 0);
    chk("rst_enc_data", 32'(bus.o_enc_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cw_cnt", 32'(cw), 0);
    chk("rst_err_sof", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(16, -1, 1'b1, -1);
    finish_test("full16");

    tight_from = cyc;
    tight = 1;
    send_frame(40, -1, 1'b1, -1);
    finish_test("frame40");
    tight = 0;

    rdy_mode = 1;
    send_frame(16, -1, 1'b1, -1);
    finish_test("stall16");
    rdy_mode = 0;

    e0 = err_cnt;
    send_frame(16, 5, 1'b1, -1);
    finish_test("sof_inj");
    chk("err_sof_pulses", 32'(err_cnt - e0), 1);

    put(8'hA5, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++)
      put(8'(i), 1'b0, 1'b0);
    bus.i_in_val  = 1'b1;
    bus.i_in_data = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_rdy", 32'(bus.o_in_rdy), 0);
    chk("mid_rst_enc_val", 32'(bus.o_enc_val), 0);
    chk("mid_rst_sop_eop",
        32'({bus.o_enc_sop, bus.o_enc_eop}), 0);
    chk("mid_rst_data", 32'(bus.o_enc_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cw_cnt", 32'(cw), 0);
    chk("mid_rst_err", 32'(err), 0);
    bus.i_in_val = 1'b0;
    got.delete();
    expq.delete();
    exp_cw = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16, -1, 1'b1, -1);
    finish_test("post_rst");

    send_frame(16, -1, 1'b0, 3);
    finish_test("en_drop");
    bus.i_in_val = 1'b1;
    bus.i_in_sof = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("en_off_in_rdy", 32'(bus.o_in_rdy), 0);
      chk("en_off_busy", 32'(busy), 0);
    end
    @(posedge clk);
    #1;
    bus.i_in_val = 1'b0;
    bus.i_in_sof = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;

    rdy_mode = 2;
    for (int f = 0; f < 5; f++) begin
      put(8'($urandom), 1'b0, 1'b0);
      send_frame($urandom_range(1, 50), -1, 1'b1, -1);
      finish_test("rand");
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
